// File: rtl/arm_mem_pkg.sv
// Shared types and constants for the SRAM-backed memory stage.
// Phase encoding, default data-space base and SRAM half-word width.
package arm_mem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      DONE = 2'd3
   } state_t;

   localparam int ADDR_OFFSET_DEF = 1024;
   localparam int HALF_W          = 16;
   localparam int WAIT_W          = 4;

endpackage

// File: rtl/sram_wait_counter.sv
// Loadable down-counter that paces each SRAM half-word phase.
// tc is high while the count sits at zero, i.e. on the last cycle of a phase.
module sram_wait_counter
   import arm_mem_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic [WAIT_W-1:0] load_value,
   output logic [WAIT_W-1:0] count,
   output logic              tc
);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= '0;
      end else if (load) begin
         count <= load_value;
      end else if (count != '0) begin
         count <= count - 1'b1;
      end
   end

   assign tc = (count == '0);

endmodule

// File: rtl/sram_mem_controller.sv
// MEM-stage back end: turns one 32-bit load/store into two 16-bit SRAM phases
// and holds ready low for the whole access so the pipeline freezes.
module sram_mem_controller
   import arm_mem_pkg::*;
#(
   parameter int ADDR_OFFSET = ADDR_OFFSET_DEF,
   parameter int SRAM_AW     = 18,
   parameter int WAIT_CYCLES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic               rd_en,
   input  logic [31:0]        address,
   input  logic [31:0]        wdata,
   output logic [31:0]        rdata,
   output logic               ready,
   output logic [SRAM_AW-1:0] sram_addr,
   output logic [HALF_W-1:0]  sram_dq_out,
   input  logic [HALF_W-1:0]  sram_dq_in,
   output logic               sram_dq_oe,
   output logic               sram_we_n,
   output state_t             fsm_state
);

   state_t             state;
   logic               op_wr;
   logic [HALF_W-1:0]  wdata_hi;
   logic [SRAM_AW-2:0] word_base;
   logic [31:0]        byte_off;
   logic [SRAM_AW-2:0] widx;
   logic               unused_off_bits;
   logic               request;
   logic               cnt_load;
   logic [WAIT_W-1:0]  cnt_value;
   logic               cnt_tc;

   // Addresses below ADDR_OFFSET wrap through the subtraction; upper bits drop.
   assign byte_off        = address - 32'(ADDR_OFFSET);
   assign widx            = byte_off[SRAM_AW:2];
   assign unused_off_bits = ^{byte_off[31:SRAM_AW+1], byte_off[1:0]};

   assign request  = wr_en | rd_en;
   assign cnt_load = ((state == IDLE) && request) || ((state == LOW) && cnt_tc);

   sram_wait_counter u_wait (
      .clk        (clk),
      .rst        (rst),
      .load       (cnt_load),
      .load_value (WAIT_W'(WAIT_CYCLES - 1)),
      .count      (cnt_value),
      .tc         (cnt_tc)
   );

   always_comb begin
      ready = 1'b0;
      case (state)
         IDLE:    ready = ~request;
         DONE:    ready = 1'b1;
         default: ready = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= IDLE;
         op_wr       <= 1'b0;
         wdata_hi    <= '0;
         word_base   <= '0;
         rdata       <= '0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_we_n   <= 1'b1;
      end else begin
         case (state)
            IDLE: begin
               if (request) begin
                  // Write wins a simultaneous request; the read is dropped.
                  op_wr       <= wr_en;
                  wdata_hi    <= wdata[31:16];
                  word_base   <= widx;
                  sram_addr   <= {widx, 1'b0};
                  sram_dq_out <= wdata[15:0];
                  sram_dq_oe  <= wr_en;
                  sram_we_n   <= ~wr_en;
                  state       <= LOW;
               end
            end
            LOW: begin
               if (cnt_tc) begin
                  if (!op_wr) rdata[15:0] <= sram_dq_in;
                  sram_addr   <= {word_base, 1'b1};
                  sram_dq_out <= wdata_hi;
                  state       <= HIGH;
               end
            end
            HIGH: begin
               if (cnt_tc) begin
                  if (!op_wr) rdata[31:16] <= sram_dq_in;
                  sram_dq_oe <= 1'b0;
                  sram_we_n  <= 1'b1;
                  state      <= DONE;
               end
            end
            // A request still held here belongs to the finished instruction.
            DONE:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign fsm_state = state;

endmodule

// File: tb/tb_sram_mem_controller.sv
// Directed bench for sram_mem_controller with WAIT_CYCLES=2 and a small
// asynchronous SRAM model on the half-word bus.
module tb_sram_mem_controller;
   import arm_mem_pkg::*;

   logic        clk;
   logic        rst;
   logic        wr_en;
   logic        rd_en;
   logic [31:0] address;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ready;
   logic [17:0] sram_addr;
   logic [15:0] sram_dq_out;
   logic [15:0] sram_dq_in;
   logic        sram_dq_oe;
   logic        sram_we_n;
   state_t      fsm_state;

   bit [15:0]   sram_mem [0:255];
   int          total;
   int          bad;

   sram_mem_controller #(
      .ADDR_OFFSET (1024),
      .SRAM_AW     (18),
      .WAIT_CYCLES (2)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .wr_en       (wr_en),
      .rd_en       (rd_en),
      .address     (address),
      .wdata       (wdata),
      .rdata       (rdata),
      .ready       (ready),
      .sram_addr   (sram_addr),
      .sram_dq_out (sram_dq_out),
      .sram_dq_in  (sram_dq_in),
      .sram_dq_oe  (sram_dq_oe),
      .sram_we_n   (sram_we_n),
      .fsm_state   (fsm_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign sram_dq_in = sram_mem[sram_addr[7:0]];

   always @(posedge clk) begin
      if (!sram_we_n) sram_mem[sram_addr[7:0]] <= sram_dq_out;
   end

   task automatic test_reset;
      int waited;
      rst = 1'b0; wr_en = 1'b1; rd_en = 1'b0; address = 32'd1100; wdata = 32'h0;
      repeat (3) begin
         @(negedge clk);
         total += 6;
         if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
         if (sram_we_n !== 1'b1) begin bad++; $display("FAIL reset_we_n got=%b exp=1", sram_we_n); end
         if (sram_dq_oe !== 1'b0) begin bad++; $display("FAIL reset_oe got=%b exp=0", sram_dq_oe); end
         if (sram_addr !== 18'h0) begin bad++; $display("FAIL reset_addr got=%h exp=0", sram_addr); end
         if (fsm_state !== IDLE) begin bad++; $display("FAIL reset_state got=%0d exp=%0d", fsm_state, IDLE); end
         if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%b exp=0", ready); end
      end
      @(posedge clk); #1 rst = 1'b1;
      #1;
      total++;
      if (ready !== 1'b0) begin bad++; $display("FAIL release_ready got=%b exp=0", ready); end
      waited = 0;
      while (ready !== 1'b1 && waited < 20) begin
         @(negedge clk);
         waited++;
      end
      total++;
      if (ready !== 1'b1) begin bad++; $display("FAIL reset_access_timeout got=%b exp=1", ready); end
      @(posedge clk); #1 wr_en = 1'b0;
   endtask

   task automatic test_write;
      @(posedge clk); #1 wr_en = 1'b1; address = 32'd1032; wdata = 32'hDEADBEEF;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         total += 3;
         if (ready !== (k == 5)) begin bad++; $display("FAIL wr_ready c%0d got=%b exp=%b", k, ready, (k == 5)); end
         if (sram_we_n !== !(k >= 1 && k <= 4)) begin bad++; $display("FAIL wr_we_n c%0d got=%b", k, sram_we_n); end
         if (sram_dq_oe !== (k >= 1 && k <= 4)) begin bad++; $display("FAIL wr_oe c%0d got=%b", k, sram_dq_oe); end
         if (k >= 1 && k <= 4) begin
            total += 2;
            if (sram_addr !== ((k <= 2) ? 18'd4 : 18'd5)) begin bad++; $display("FAIL wr_addr c%0d got=%0d", k, sram_addr); end
            if (sram_dq_out !== ((k <= 2) ? 16'hBEEF : 16'hDEAD)) begin bad++; $display("FAIL wr_dq c%0d got=%h", k, sram_dq_out); end
         end
         @(posedge clk); #1;
      end
      wr_en = 1'b0;
      @(negedge clk);
      total += 3;
      if (sram_mem[4] !== 16'hBEEF || sram_mem[5] !== 16'hDEAD) begin
         bad++; $display("FAIL wr_mem got=%h_%h exp=dead_beef", sram_mem[5], sram_mem[4]);
      end
      if (rdata !== 32'h0) begin bad++; $display("FAIL wr_rdata_kept got=%h exp=0", rdata); end
      if (ready !== 1'b1) begin bad++; $display("FAIL wr_idle_ready got=%b exp=1", ready); end
   endtask

   task automatic test_read;
      @(posedge clk); #1 rd_en = 1'b1; address = 32'd1032;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         total += 2;
         if (ready !== (k == 5)) begin bad++; $display("FAIL rd_ready c%0d got=%b exp=%b", k, ready, (k == 5)); end
         if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin bad++; $display("FAIL rd_strobe c%0d we_n=%b oe=%b", k, sram_we_n, sram_dq_oe); end
         if (k == 1 || k == 3) begin
            total++;
            if (sram_addr !== ((k == 1) ? 18'd4 : 18'd5)) begin bad++; $display("FAIL rd_addr c%0d got=%0d", k, sram_addr); end
         end
         if (k == 5) begin
            total++;
            if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL rd_data got=%h exp=deadbeef", rdata); end
         end
         @(posedge clk); #1;
      end
      rd_en = 1'b0;
   endtask

   task automatic test_simultaneous;
      @(posedge clk); #1 wr_en = 1'b1; rd_en = 1'b1; address = 32'd1024; wdata = 32'h12345678;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         total++;
         if (ready !== (k == 5)) begin bad++; $display("FAIL sim_ready c%0d got=%b exp=%b", k, ready, (k == 5)); end
         if (k == 1) begin
            total++;
            if (sram_we_n !== 1'b0) begin bad++; $display("FAIL sim_we_n got=%b exp=0", sram_we_n); end
         end
         @(posedge clk); #1;
      end
      wr_en = 1'b0; rd_en = 1'b0;
      @(negedge clk);
      total += 2;
      if (sram_mem[0] !== 16'h5678 || sram_mem[1] !== 16'h1234) begin
         bad++; $display("FAIL sim_mem got=%h_%h exp=1234_5678", sram_mem[1], sram_mem[0]);
      end
      if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL sim_rdata got=%h exp=deadbeef", rdata); end
   endtask

   task automatic test_back_to_back;
      logic [11:0] exp_ready;
      exp_ready = 12'b1000_0010_0000;
      @(posedge clk); #1 rd_en = 1'b1; address = 32'd1024;
      for (int k = 0; k <= 11; k++) begin
         @(negedge clk);
         total++;
         if (ready !== exp_ready[k]) begin bad++; $display("FAIL b2b_ready c%0d got=%b exp=%b", k, ready, exp_ready[k]); end
         if (k == 5) begin
            total++;
            if (rdata !== 32'h12345678) begin bad++; $display("FAIL b2b_rdata got=%h exp=12345678", rdata); end
         end
         if (k == 6) begin
            total++;
            if (fsm_state !== IDLE) begin bad++; $display("FAIL b2b_idle got=%0d exp=%0d", fsm_state, IDLE); end
         end
         if (k == 7) begin
            total++;
            if (sram_we_n !== 1'b0 || sram_addr !== 18'd2) begin
               bad++; $display("FAIL b2b_second we_n=%b addr=%0d exp we_n=0 addr=2", sram_we_n, sram_addr);
            end
         end
         @(posedge clk); #1;
         if (k == 5) begin
            rd_en = 1'b0; wr_en = 1'b1; address = 32'd1028; wdata = 32'hAAAA5555;
         end
      end
      wr_en = 1'b0;
      @(negedge clk);
      total++;
      if (sram_mem[2] !== 16'h5555 || sram_mem[3] !== 16'hAAAA) begin
         bad++; $display("FAIL b2b_mem got=%h_%h exp=aaaa_5555", sram_mem[3], sram_mem[2]);
      end
   endtask

   task automatic test_wrap;
      @(posedge clk); #1 rd_en = 1'b1; address = 32'd1020;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         if (k == 1 || k == 3) begin
            total++;
            if (sram_addr !== ((k == 1) ? 18'h3FFFE : 18'h3FFFF)) begin bad++; $display("FAIL wrap_addr c%0d got=%h", k, sram_addr); end
         end
         if (k == 5) begin
            total++;
            if (rdata !== 32'h0) begin bad++; $display("FAIL wrap_rdata got=%h exp=0", rdata); end
         end
         @(posedge clk); #1;
      end
      rd_en = 1'b0;
   endtask

   task automatic test_reset_mid_access;
      @(posedge clk); #1 wr_en = 1'b1; address = 32'd1040; wdata = 32'h0BADF00D;
      repeat (3) begin
         @(posedge clk); #1;
      end
      @(negedge clk);
      total++;
      if (fsm_state !== HIGH) begin bad++; $display("FAIL mid_in_high got=%0d exp=%0d", fsm_state, HIGH); end
      #1 rst = 1'b0;
      #1;
      total += 3;
      if (sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) begin bad++; $display("FAIL mid_strobe we_n=%b oe=%b", sram_we_n, sram_dq_oe); end
      if (fsm_state !== IDLE) begin bad++; $display("FAIL mid_state got=%0d exp=%0d", fsm_state, IDLE); end
      if (rdata !== 32'h0) begin bad++; $display("FAIL mid_rdata got=%h exp=0", rdata); end
      @(posedge clk); #1 wr_en = 1'b0;
      @(posedge clk); #1 rst = 1'b1;
      @(negedge clk);
      total++;
      if (fsm_state !== IDLE || ready !== 1'b1) begin bad++; $display("FAIL mid_release state=%0d ready=%b", fsm_state, ready); end
      @(posedge clk); #1 rd_en = 1'b1; address = 32'd1032;
      for (int k = 0; k <= 5; k++) begin
         @(negedge clk);
         total++;
         if (ready !== (k == 5)) begin bad++; $display("FAIL mid_rd_ready c%0d got=%b", k, ready); end
         if (k == 5) begin
            total++;
            if (rdata !== 32'hDEADBEEF) begin bad++; $display("FAIL mid_rd_data got=%h exp=deadbeef", rdata); end
         end
         @(posedge clk); #1;
      end
      rd_en = 1'b0;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_write();
      test_read();
      test_simultaneous();
      test_back_to_back();
      test_wrap();
      test_reset_mid_access();
      repeat (2) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
